pkt_formatter: RTL and testbench
================================

PKT_FORMATTER -- requirements
Module: pkt_formatter

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 2, giving the number of idle cycles after each packet (legal 1..15).
REQ-002 The block SHALL have the following ports, one clock and one reset; reset is asynchronous and active-low:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  packet request present
- req_addr  in  2  destination port, legal 0..2
- req_len  in  6  payload length in bytes, 0..63
- req_ready  out  1  request accepted when req_valid && req_ready
- pl_valid  in  1  payload byte present
- pl_data  in  8  payload byte
- pl_ready  out  1  payload byte accepted when pl_valid && pl_ready
- busy  in  1  router stall; high = current data_out not consumed
- pkt_valid  out  1  router packet-valid
- data_out  out  8  router data byte (drives router data_in)
- pkt_done  out  1  one-cycle pulse, packet parity byte consumed
- drop  out  1  one-cycle pulse, request rejected

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, HDR, PLD, PAR and GAP.
REQ-004 In IDLE, req_ready SHALL be 1 and all other outputs 0; on accept, latch addr/len and go to LOAD (len>0), HDR (len=0), or stay IDLE with drop=1 next cycle (addr=3).
REQ-005 In LOAD, pl_ready SHALL be 1; each accepted byte is written to a 64x8 internal buffer at an incrementing index; after the len-th byte, go to HDR.
REQ-006 Header byte SHALL be {len[5:0], addr[1:0]}.
REQ-007 A byte is consumed on a rising edge where the block presents it and busy==0; with busy==1 data_out, pkt_valid and state SHALL hold unchanged.
REQ-008 In HDR and PLD, pkt_valid SHALL be 1 and data_out the header, then buffer bytes 0..len-1 in order, one per consumed edge.
REQ-009 In PAR, pkt_valid SHALL be 0 and data_out SHALL be the XOR of the header and all payload bytes.
REQ-010 pkt_done SHALL pulse for one cycle in the cycle after the parity byte is consumed; the FSM then goes to GAP.
REQ-011 GAP SHALL last exactly GAP_CYCLES cycles with all outputs 0, then return to IDLE.
REQ-012 len=0 SHALL send only header then parity (parity = header).
REQ-013 busy SHALL be ignored in IDLE, LOAD and GAP.
REQ-014 req_valid outside IDLE SHALL be ignored; pl_valid outside LOAD SHALL be ignored.
REQ-015 Minimum latency SHALL be: header driven the cycle after the last payload byte is accepted (or after request accept for len=0).

Reset
REQ-016 While resetn=0, the block SHALL force FSM=IDLE, counters=0, and all outputs (req_ready, pl_ready, pkt_valid, data_out, pkt_done, drop) = 0, asynchronously.
REQ-017 Buffer contents SHALL NOT be reset.
REQ-018 Reset mid-packet SHALL abort the packet with no pkt_done.
REQ-019 req_ready SHALL rise on the first clock edge after resetn deasserts.

Configuration
REQ-020 With PKT_FMT_PAR_INJ_EN defined, the block SHALL add input par_inj (1 bit), sampled at request accept; when 1, that packet's parity byte SHALL be inverted (bitwise NOT).
REQ-021 Without PKT_FMT_PAR_INJ_EN, port par_inj SHALL NOT exist and parity SHALL always be correct.

Verification
REQ-022 The bench SHALL drive addr=1, len=3, payload 0x11,0x22,0x33 with busy=0 -> data_out 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0, then pkt_done one cycle.
REQ-023 The bench SHALL drive the REQ-022 packet with busy=1 for 4 cycles while 0x22 is presented -> 0x22 and pkt_valid held 4 cycles, sequence otherwise unchanged.
REQ-024 The bench SHALL drive addr=3, len=5 -> drop pulse, no pkt_valid, pl_ready stays 0, req_ready back to 1 next cycle.
REQ-025 The bench SHALL drive addr=2, len=0 -> header 0x02 with pkt_valid=1, parity 0x02 with pkt_valid=0, then exactly GAP_CYCLES idle cycles before req_ready=1.
REQ-026 The bench SHALL drive len=63 with bytes 0..62 -> header 0xFC, 63 payload bytes in order, parity = 0xFC XOR (0^1^...^62).
REQ-027 The bench SHALL deassert resetn during PLD -> outputs 0 immediately, no pkt_done, next request sent correctly.

Source files
------------

// File: rtl/pkt_formatter.sv
// Packet formatter: buffers a payload, then streams header, payload and XOR parity to a router.
// Optional build macro PKT_FMT_PAR_INJ_EN adds input par_inj to invert one packet's parity byte.
module pkt_formatter #(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       resetn,
`ifdef PKT_FMT_PAR_INJ_EN
    input  logic       par_inj,
`endif
    input  logic       req_valid,
    input  logic [1:0] req_addr,
    input  logic [5:0] req_len,
    output logic       req_ready,
    input  logic       pl_valid,
    input  logic [7:0] pl_data,
    output logic       pl_ready,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       pkt_done,
    output logic       drop
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HDR,
        PLD,
        PAR,
        GAP
    } state_t;

    localparam logic [5:0] GAP_LAST = 6'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [5:0] len_q, len_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] par_q, par_d;
    logic       ready_en_q, ready_en_d;
    logic       drop_q, drop_d;
    logic       done_q, done_d;
    logic       inj_q, inj_d;
    logic       wr_en;
    logic [7:0] par_out;
    logic [7:0] pl_buf [64];

`ifdef PKT_FMT_PAR_INJ_EN
    logic inj_sample;
    assign inj_sample = par_inj;
`else
    logic inj_sample;
    assign inj_sample = 1'b0;
`endif

    assign par_out = inj_q ? ~par_q : par_q;

    // Parity accumulates from the header at accept time, so it is ready when PAR is reached.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        par_d      = par_q;
        inj_d      = inj_q;
        ready_en_d = 1'b1;
        drop_d     = 1'b0;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        req_ready  = 1'b0;
        pl_ready   = 1'b0;
        pkt_valid  = 1'b0;
        data_out   = 8'h00;

        case (state_q)
            IDLE: begin
                req_ready = ready_en_q;
                if (req_valid && ready_en_q) begin
                    if (req_addr == 2'd3) begin
                        drop_d = 1'b1;
                    end else begin
                        addr_d  = req_addr;
                        len_d   = req_len;
                        cnt_d   = 6'd0;
                        par_d   = {req_len, req_addr};
                        inj_d   = inj_sample;
                        state_d = (req_len == 6'd0) ? HDR : LOAD;
                    end
                end
            end
            LOAD: begin
                pl_ready = 1'b1;
                if (pl_valid) begin
                    wr_en = 1'b1;
                    par_d = par_q ^ pl_data;
                    if (cnt_q == len_q - 6'd1) begin
                        cnt_d   = 6'd0;
                        state_d = HDR;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            HDR: begin
                pkt_valid = 1'b1;
                data_out  = {len_q, addr_q};
                if (!busy) begin
                    cnt_d   = 6'd0;
                    state_d = (len_q == 6'd0) ? PAR : PLD;
                end
            end
            PLD: begin
                pkt_valid = 1'b1;
                data_out  = pl_buf[cnt_q];
                if (!busy) begin
                    if (cnt_q == len_q - 6'd1) begin
                        cnt_d   = 6'd0;
                        state_d = PAR;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            PAR: begin
                data_out = par_out;
                if (!busy) begin
                    done_d  = 1'b1;
                    cnt_d   = 6'd0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 6'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    assign drop     = drop_q;
    assign pkt_done = done_q;

    // ready_en_q keeps req_ready low until the first edge after reset is released.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            addr_q     <= 2'd0;
            len_q      <= 6'd0;
            cnt_q      <= 6'd0;
            par_q      <= 8'h00;
            inj_q      <= 1'b0;
            ready_en_q <= 1'b0;
            drop_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            par_q      <= par_d;
            inj_q      <= inj_d;
            ready_en_q <= ready_en_d;
            drop_q     <= drop_d;
            done_q     <= done_d;
        end
    end

    // Payload storage deliberately survives reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pl_buf[cnt_q] <= pl_data;
        end
    end

endmodule

// File: tb/tb_pkt_formatter.sv
// Directed self-checking bench for pkt_formatter (default build, GAP_CYCLES = 2).
module tb_pkt_formatter;

    localparam int GAP_CYCLES = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_addr = 2'd0;
    logic [5:0] req_len = 6'd0;
    logic       pl_valid = 1'b0;
    logic [7:0] pl_data = 8'h00;
    logic       busy = 1'b0;
    logic       req_ready;
    logic       pl_ready;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       pkt_done;
    logic       drop;
`ifdef PKT_FMT_PAR_INJ_EN
    logic       par_inj = 1'b0;
`endif

    int n_checks = 0;
    int n_fails = 0;
    logic [7:0] payload [64];
    logic [7:0] exp_seq [4];

    pkt_formatter #(.GAP_CYCLES(GAP_CYCLES)) dut (
        .clk       (clk),
        .resetn    (resetn),
`ifdef PKT_FMT_PAR_INJ_EN
        .par_inj   (par_inj),
`endif
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_ready (req_ready),
        .pl_valid  (pl_valid),
        .pl_data   (pl_data),
        .pl_ready  (pl_ready),
        .busy      (busy),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .pkt_done  (pkt_done),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [1:0] a, input logic [5:0] l);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic load_payload(input int n);
        for (int i = 0; i < n; i++) begin
            pl_valid = 1'b1;
            pl_data  = payload[i];
            tick();
        end
        pl_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({req_ready, pl_ready, pkt_valid, pkt_done, drop, data_out} !== 13'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_outputs: got %b required all zero",
                     {req_ready, pl_ready, pkt_valid, pkt_done, drop, data_out});
        end
        tick();
        resetn = 1'b1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL ready_before_edge: got %b required 0", req_ready);
        end
        tick();
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL ready_after_edge: got %b required 1", req_ready);
        end
    endtask

    task automatic test_basic(input logic stall);
        payload[0] = 8'h11;
        payload[1] = 8'h22;
        payload[2] = 8'h33;
        exp_seq = '{8'h0D, 8'h11, 8'h22, 8'h33};
        request(2'd1, 6'd3);
        n_checks++;
        if (pl_ready !== 1'b1 || req_ready !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL load_ready: got pl_ready=%b req_ready=%b required 1/0", pl_ready, req_ready);
        end
        load_payload(3);
        for (int i = 0; i < 4; i++) begin
            if (stall && i == 2) begin
                busy = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    n_checks++;
                    if (pkt_valid !== 1'b1 || data_out !== 8'h22) begin
                        n_fails++;
                        $display("[TB] FAIL stall_hold[%0d]: got valid=%b data=%h required 1/22", k, pkt_valid, data_out);
                    end
                    tick();
                end
                busy = 1'b0;
            end
            n_checks++;
            if (pkt_valid !== 1'b1 || data_out !== exp_seq[i]) begin
                n_fails++;
                $display("[TB] FAIL stream[%0d]: got valid=%b data=%h required 1/%h", i, pkt_valid, data_out, exp_seq[i]);
            end
            tick();
        end
        n_checks++;
        if (pkt_valid !== 1'b0 || data_out !== 8'h0D || pkt_done !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL parity: got valid=%b data=%h done=%b required 0/0d/0", pkt_valid, data_out, pkt_done);
        end
        tick();
        // busy during GAP has no effect on its length
        busy = stall;
        for (int g = 0; g < GAP_CYCLES; g++) begin
            n_checks++;
            if (pkt_done !== (g == 0) || req_ready !== 1'b0 || pkt_valid !== 1'b0 || data_out !== 8'h00) begin
                n_fails++;
                $display("[TB] FAIL gap[%0d]: got done=%b ready=%b valid=%b data=%h", g, pkt_done, req_ready, pkt_valid, data_out);
            end
            tick();
        end
        busy = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1 || pkt_done !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL back_to_idle: got ready=%b done=%b required 1/0", req_ready, pkt_done);
        end
    endtask

    task automatic test_drop();
        request(2'd3, 6'd5);
        n_checks++;
        if (drop !== 1'b1 || req_ready !== 1'b1 || pl_ready !== 1'b0 || pkt_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL drop_pulse: got drop=%b ready=%b pl_ready=%b valid=%b required 1/1/0/0", drop, req_ready, pl_ready, pkt_valid);
        end
        tick();
        n_checks++;
        if (drop !== 1'b0 || req_ready !== 1'b1 || pl_ready !== 1'b0 || pkt_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL drop_after: got drop=%b ready=%b pl_ready=%b valid=%b required 0/1/0/0", drop, req_ready, pl_ready, pkt_valid);
        end
    endtask

    task automatic test_len_zero();
        request(2'd2, 6'd0);
        n_checks++;
        if (pkt_valid !== 1'b1 || data_out !== 8'h02) begin
            n_fails++;
            $display("[TB] FAIL len0_header: got valid=%b data=%h required 1/02", pkt_valid, data_out);
        end
        tick();
        n_checks++;
        if (pkt_valid !== 1'b0 || data_out !== 8'h02) begin
            n_fails++;
            $display("[TB] FAIL len0_parity: got valid=%b data=%h required 0/02", pkt_valid, data_out);
        end
        tick();
        for (int g = 0; g < GAP_CYCLES; g++) begin
            n_checks++;
            if (pkt_done !== (g == 0) || req_ready !== 1'b0) begin
                n_fails++;
                $display("[TB] FAIL len0_gap[%0d]: got done=%b ready=%b", g, pkt_done, req_ready);
            end
            tick();
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL len0_idle: got ready=%b required 1", req_ready);
        end
    endtask

    task automatic test_len_max();
        for (int i = 0; i < 63; i++) payload[i] = 8'(i);
        request(2'd0, 6'd63);
        load_payload(63);
        n_checks++;
        if (pkt_valid !== 1'b1 || data_out !== 8'hFC) begin
            n_fails++;
            $display("[TB] FAIL len63_header: got valid=%b data=%h required 1/fc", pkt_valid, data_out);
        end
        tick();
        for (int i = 0; i < 63; i++) begin
            n_checks++;
            if (pkt_valid !== 1'b1 || data_out !== 8'(i)) begin
                n_fails++;
                $display("[TB] FAIL len63_byte[%0d]: got valid=%b data=%h required 1/%h", i, pkt_valid, data_out, 8'(i));
            end
            tick();
        end
        // XOR of 0..62 is 0x3F, so parity is 0xFC ^ 0x3F
        n_checks++;
        if (pkt_valid !== 1'b0 || data_out !== 8'hC3) begin
            n_fails++;
            $display("[TB] FAIL len63_parity: got valid=%b data=%h required 0/c3", pkt_valid, data_out);
        end
        tick();
        n_checks++;
        if (pkt_done !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL len63_done: got %b required 1", pkt_done);
        end
        repeat (GAP_CYCLES) tick();
    endtask

    task automatic test_reset_mid_packet();
        payload[0] = 8'h11;
        payload[1] = 8'h22;
        payload[2] = 8'h33;
        request(2'd1, 6'd3);
        load_payload(3);
        tick();
        n_checks++;
        if (pkt_valid !== 1'b1 || data_out !== 8'h11) begin
            n_fails++;
            $display("[TB] FAIL mid_pld: got valid=%b data=%h required 1/11", pkt_valid, data_out);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, pl_ready, pkt_valid, pkt_done, drop, data_out} !== 13'b0) begin
            n_fails++;
            $display("[TB] FAIL mid_reset_outputs: got %b required all zero",
                     {req_ready, pl_ready, pkt_valid, pkt_done, drop, data_out});
        end
        tick();
        resetn = 1'b1;
        tick();
        n_checks++;
        if (req_ready !== 1'b1 || pkt_done !== 1'b0 || pkt_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL mid_recover: got ready=%b done=%b valid=%b required 1/0/0", req_ready, pkt_done, pkt_valid);
        end
        payload[0] = 8'hA5;
        request(2'd2, 6'd1);
        load_payload(1);
        exp_seq = '{8'h06, 8'hA5, 8'hA3, 8'h00};
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (pkt_valid !== (i < 2) || data_out !== exp_seq[i]) begin
                n_fails++;
                $display("[TB] FAIL next_pkt[%0d]: got valid=%b data=%h required %b/%h", i, pkt_valid, data_out, (i < 2), exp_seq[i]);
            end
            tick();
        end
        n_checks++;
        if (pkt_done !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL next_pkt_done: got %b required 1", pkt_done);
        end
        repeat (GAP_CYCLES) tick();
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_drop();
        test_len_zero();
        test_len_max();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
